// File: rtl/vmem_pkg.sv
// Shared types and constants for the video-memory write arbiter.
package vmem_pkg;

    localparam int ADDR_W = 19;
    localparam int DATA_W = 24;
    localparam int H_BITS = 10;
    localparam int V_BITS = 9;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_t;

endpackage

// File: rtl/vmem_arb_pick.sv
// Two-way round-robin picker: one-hot grant from the valids and the priority pointer.
module vmem_arb_pick (
    input  logic [1:0] valid_i,
    input  logic       prio_i,
    output logic [1:0] grant_o
);

    always_comb begin
        grant_o = 2'b00;
        case (valid_i)
            2'b01:   grant_o = 2'b01;
            2'b10:   grant_o = 2'b10;
            2'b11:   grant_o = prio_i ? 2'b10 : 2'b01;
            default: grant_o = 2'b00;
        endcase
    end

endmodule

// File: rtl/vmem_wr_arb.sv
// Round-robin, burst-locking write arbiter in front of the VGA video memory.
// Define VMEM_BLANK_WR_EN to restrict writes (and lock timeout counting) to blanking.
module vmem_wr_arb #(
    parameter int ADDR_W       = vmem_pkg::ADDR_W,
    parameter int DATA_W       = vmem_pkg::DATA_W,
    parameter int LOCK_TIMEOUT = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_data,
    input  logic              req0_last,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_data,
    input  logic              req1_last,
    output logic              req1_ready,
    input  logic              vga_valid,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_waddr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              busy,
    output logic              grant_id,
    output logic              timeout_pulse
);

    import vmem_pkg::*;

    localparam int              CNT_W   = (LOCK_TIMEOUT > 1) ? $clog2(LOCK_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(LOCK_TIMEOUT - 1);

    arb_state_t        state_q;
    logic              prio_q;
    logic              owner_q;
    logic              timeout_q;
    logic              we_q;
    logic [ADDR_W-1:0] waddr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_d;

    logic              wr_gate;
    logic [1:0]        valid_v;
    logic [1:0]        pick;
    logic [1:0]        ready_v;
    logic              xfer;
    logic              win;
    logic              last_v;
    logic [ADDR_W-1:0] addr_v;
    logic [DATA_W-1:0] data_v;

`ifdef VMEM_BLANK_WR_EN
    // Writes and lock aging are both frozen during active video.
    assign wr_gate = ~vga_valid;
`else
    logic unused_vga;
    assign unused_vga = vga_valid;
    assign wr_gate    = 1'b1;
`endif

    assign valid_v = {req1_valid, req0_valid};

    vmem_arb_pick u_pick (
        .valid_i (valid_v),
        .prio_i  (prio_q),
        .grant_o (pick)
    );

    always_comb begin
        ready_v = 2'b00;
        if (wr_gate) begin
            if (state_q == IDLE) ready_v = pick;
            else                 ready_v = owner_q ? 2'b10 : 2'b01;
        end
    end

    assign req0_ready = ready_v[0];
    assign req1_ready = ready_v[1];

    assign xfer   = |(ready_v & valid_v);
    assign win    = ready_v[1];
    assign last_v = win ? req1_last : req0_last;
    assign addr_v = win ? req1_addr : req0_addr;
    assign data_v = win ? req1_data : req0_data;

    // Saturating increment so the counter can never wrap.
    assign cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            prio_q    <= 1'b0;
            owner_q   <= 1'b0;
            timeout_q <= 1'b0;
            we_q      <= 1'b0;
            waddr_q   <= '0;
            wdata_q   <= '0;
            cnt_q     <= '0;
        end else begin
            we_q      <= xfer;
            timeout_q <= 1'b0;
            if (xfer) begin
                waddr_q <= addr_v;
                wdata_q <= data_v;
            end
            case (state_q)
                IDLE: begin
                    if (xfer) begin
                        owner_q <= win;
                        cnt_q   <= '0;
                        if (last_v) prio_q  <= ~win;
                        else        state_q <= BURST;
                    end
                end
                BURST: begin
                    if (xfer) begin
                        cnt_q <= '0;
                        if (last_v) begin
                            state_q <= IDLE;
                            prio_q  <= ~owner_q;
                        end
                    end else if (wr_gate) begin
                        if (cnt_q == CNT_MAX) begin
                            state_q   <= IDLE;
                            prio_q    <= ~owner_q;
                            timeout_q <= 1'b1;
                            cnt_q     <= '0;
                        end else begin
                            cnt_q <= cnt_d;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign mem_we        = we_q;
    assign mem_waddr     = waddr_q;
    assign mem_wdata     = wdata_q;
    assign busy          = (state_q == BURST);
    assign grant_id      = owner_q;
    assign timeout_pulse = timeout_q;

endmodule

// File: tb/tb_vmem_wr_arb.sv
// Directed self-checking bench for vmem_wr_arb (LOCK_TIMEOUT shortened to 8).
module tb_vmem_wr_arb;

    localparam int AW = 19;
    localparam int DW = 24;
    localparam int LT = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req0_valid, req0_last, req0_ready;
    logic [AW-1:0] req0_addr;
    logic [DW-1:0] req0_data;
    logic          req1_valid, req1_last, req1_ready;
    logic [AW-1:0] req1_addr;
    logic [DW-1:0] req1_data;
    logic          vga_valid;
    logic          mem_we, busy, grant_id, timeout_pulse;
    logic [AW-1:0] mem_waddr;
    logic [DW-1:0] mem_wdata;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    vmem_wr_arb #(.ADDR_W(AW), .DATA_W(DW), .LOCK_TIMEOUT(LT)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data),
        .req0_last(req0_last), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data),
        .req1_last(req1_last), .req1_ready(req1_ready),
        .vga_valid(vga_valid),
        .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
        .busy(busy), .grant_id(grant_id), .timeout_pulse(timeout_pulse)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        req0_valid = 1'b0; req0_last = 1'b0; req0_addr = '0; req0_data = '0;
        req1_valid = 1'b0; req1_last = 1'b0; req1_addr = '0; req1_data = '0;
        vga_valid  = 1'b0;
    endtask

    task automatic do_reset;
        idle_inputs();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset;
        do_reset();
        n_cmp++;
        if ({mem_we, busy, grant_id, timeout_pulse} !== 4'b0000) begin
            n_err++;
            $display("FAIL reset_ctrl: got we/busy/gid/to=%b required 0000",
                     {mem_we, busy, grant_id, timeout_pulse});
        end
        n_cmp++;
        if (mem_waddr !== '0 || mem_wdata !== '0) begin
            n_err++;
            $display("FAIL reset_addr_data: got %h/%h required 0/0", mem_waddr, mem_wdata);
        end
        n_cmp++;
        if ({req1_ready, req0_ready} !== 2'b00) begin
            n_err++;
            $display("FAIL reset_ready: got %b required 00", {req1_ready, req0_ready});
        end
    endtask

    task automatic test_single;
        do_reset();
        req0_valid = 1'b1; req0_addr = 19'h00001; req0_data = 24'hFF0000; req0_last = 1'b1;
        #1;
        n_cmp++;
        if ({req1_ready, req0_ready} !== 2'b01) begin
            n_err++;
            $display("FAIL single_ready: got %b required 01", {req1_ready, req0_ready});
        end
        tick();
        req0_valid = 1'b0;
        n_cmp++;
        if (mem_we !== 1'b1 || mem_waddr !== 19'h00001 || mem_wdata !== 24'hFF0000) begin
            n_err++;
            $display("FAIL single_write: got we=%b %h/%h required 1 00001/ff0000",
                     mem_we, mem_waddr, mem_wdata);
        end
        n_cmp++;
        if (grant_id !== 1'b0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL single_gid: got gid=%b busy=%b required 0 0", grant_id, busy);
        end
        tick();
        n_cmp++;
        if (mem_we !== 1'b0 || mem_waddr !== 19'h00001) begin
            n_err++;
            $display("FAIL single_hold: got we=%b addr=%h required 0 00001", mem_we, mem_waddr);
        end
    endtask

    task automatic test_alternate;
        logic [AW-1:0] ea;
        logic [DW-1:0] ed;
        do_reset();
        req0_valid = 1'b1; req0_last = 1'b1;
        req1_valid = 1'b1; req1_last = 1'b1;
        for (int i = 0; i < 4; i++) begin
            req0_addr = 19'h00010 + AW'(i); req0_data = 24'hFFFFFF - DW'(i);
            req1_addr = 19'h7FFF0 + AW'(i); req1_data = 24'h000100 * DW'(i);
            ea = (i % 2 == 0) ? req0_addr : req1_addr;
            ed = (i % 2 == 0) ? req0_data : req1_data;
            #1;
            n_cmp++;
            if ({req1_ready, req0_ready} !== ((i % 2 == 0) ? 2'b01 : 2'b10)) begin
                n_err++;
                $display("FAIL alt_ready[%0d]: got %b required %b", i,
                         {req1_ready, req0_ready}, (i % 2 == 0) ? 2'b01 : 2'b10);
            end
            tick();
            n_cmp++;
            if (mem_we !== 1'b1 || mem_waddr !== ea || mem_wdata !== ed) begin
                n_err++;
                $display("FAIL alt_write[%0d]: got we=%b %h/%h required 1 %h/%h", i,
                         mem_we, mem_waddr, mem_wdata, ea, ed);
            end
        end
        idle_inputs();
    endtask

    task automatic test_burst;
        do_reset();
        req1_valid = 1'b1; req1_last = 1'b1; req1_addr = 19'h00222; req1_data = 24'h00FF00;
        req0_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            req0_addr = 19'h00100 + AW'(i); req0_data = 24'h0000A0 + DW'(i);
            req0_last = (i == 2);
            #1;
            n_cmp++;
            if ({req1_ready, req0_ready} !== 2'b01) begin
                n_err++;
                $display("FAIL burst_ready[%0d]: got %b required 01", i, {req1_ready, req0_ready});
            end
            n_cmp++;
            if (busy !== (i != 0)) begin
                n_err++;
                $display("FAIL burst_busy[%0d]: got %b required %b", i, busy, (i != 0));
            end
            tick();
            n_cmp++;
            if (mem_we !== 1'b1 || mem_waddr !== 19'h00100 + AW'(i)) begin
                n_err++;
                $display("FAIL burst_write[%0d]: got we=%b addr=%h required 1 %h", i,
                         mem_we, mem_waddr, 19'h00100 + AW'(i));
            end
        end
        req0_valid = 1'b0;
        #1;
        n_cmp++;
        if ({req1_ready, req0_ready} !== 2'b10 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL burst_release: got rdy=%b busy=%b required 10 0",
                     {req1_ready, req0_ready}, busy);
        end
        tick();
        n_cmp++;
        if (mem_we !== 1'b1 || mem_waddr !== 19'h00222 || grant_id !== 1'b1) begin
            n_err++;
            $display("FAIL burst_next: got we=%b addr=%h gid=%b required 1 00222 1",
                     mem_we, mem_waddr, grant_id);
        end
        idle_inputs();
    endtask

    task automatic test_timeout;
        do_reset();
        req1_valid = 1'b1; req1_last = 1'b1; req1_addr = 19'h00333; req1_data = 24'h0000FF;
        req0_valid = 1'b1; req0_last = 1'b0; req0_addr = 19'h00044; req0_data = 24'h123456;
        tick();
        req0_valid = 1'b0;
        for (int i = 1; i < LT; i++) begin
            tick();
            n_cmp++;
            if (timeout_pulse !== 1'b0 || busy !== 1'b1 || req1_ready !== 1'b0) begin
                n_err++;
                $display("FAIL to_wait[%0d]: got to=%b busy=%b r1=%b required 0 1 0", i,
                         timeout_pulse, busy, req1_ready);
            end
        end
        tick();
        n_cmp++;
        if (timeout_pulse !== 1'b1 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL to_fire: got to=%b busy=%b required 1 0", timeout_pulse, busy);
        end
        n_cmp++;
        if (req1_ready !== 1'b1) begin
            n_err++;
            $display("FAIL to_regrant: got r1=%b required 1", req1_ready);
        end
        tick();
        n_cmp++;
        if (timeout_pulse !== 1'b0 || mem_we !== 1'b1 || mem_waddr !== 19'h00333) begin
            n_err++;
            $display("FAIL to_after: got to=%b we=%b addr=%h required 0 1 00333",
                     timeout_pulse, mem_we, mem_waddr);
        end
        idle_inputs();
    endtask

    task automatic test_reset_mid_burst;
        do_reset();
        req1_valid = 1'b1; req1_last = 1'b0; req1_addr = 19'h00555; req1_data = 24'hABCDEF;
        tick();
        n_cmp++;
        if (busy !== 1'b1 || grant_id !== 1'b1) begin
            n_err++;
            $display("FAIL rmb_lock: got busy=%b gid=%b required 1 1", busy, grant_id);
        end
        req0_valid = 1'b1; req0_last = 1'b1;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_cmp++;
        if (busy !== 1'b0 || mem_we !== 1'b0 || grant_id !== 1'b0) begin
            n_err++;
            $display("FAIL rmb_state: got busy=%b we=%b gid=%b required 0 0 0",
                     busy, mem_we, grant_id);
        end
        req1_last = 1'b1;
        #1;
        n_cmp++;
        if ({req1_ready, req0_ready} !== 2'b01) begin
            n_err++;
            $display("FAIL rmb_prio: got %b required 01", {req1_ready, req0_ready});
        end
        idle_inputs();
    endtask

    task automatic test_blank;
        do_reset();
`ifdef VMEM_BLANK_WR_EN
        vga_valid = 1'b1;
        req0_valid = 1'b1; req0_last = 1'b0; req0_addr = 19'h00777; req0_data = 24'h777777;
        for (int i = 0; i < 20; i++) begin
            #1;
            n_cmp++;
            if (req0_ready !== 1'b0 || timeout_pulse !== 1'b0) begin
                n_err++;
                $display("FAIL blank_hold[%0d]: got r0=%b to=%b required 0 0", i,
                         req0_ready, timeout_pulse);
            end
            tick();
        end
        vga_valid = 1'b0;
        #1;
        n_cmp++;
        if (req0_ready !== 1'b1) begin
            n_err++;
            $display("FAIL blank_open: got r0=%b required 1", req0_ready);
        end
        tick();
        req0_valid = 1'b0;
        vga_valid  = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            n_cmp++;
            if (busy !== 1'b1 || timeout_pulse !== 1'b0) begin
                n_err++;
                $display("FAIL blank_lock[%0d]: got busy=%b to=%b required 1 0", i,
                         busy, timeout_pulse);
            end
        end
`else
        vga_valid = 1'b1;
        req0_valid = 1'b1; req0_last = 1'b1; req0_addr = 19'h00777; req0_data = 24'h777777;
        #1;
        n_cmp++;
        if (req0_ready !== 1'b1) begin
            n_err++;
            $display("FAIL vga_ignored: got r0=%b required 1", req0_ready);
        end
        tick();
        n_cmp++;
        if (mem_we !== 1'b1 || mem_waddr !== 19'h00777) begin
            n_err++;
            $display("FAIL vga_write: got we=%b addr=%h required 1 00777", mem_we, mem_waddr);
        end
`endif
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_single();
        test_alternate();
        test_burst();
        test_timeout();
        test_reset_mid_burst();
        test_blank();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
